// File: rtl/controle_mic_fsm.sv
// Microwave controller: keypad time entry, seconds prescaler and cook-time
// down-counter with pause/resume, door interlock, quick-start and done pulse.
module controle_mic_fsm #(
  parameter int TW        = 12,
  parameter int TICK_DIV  = 100,
  parameter int QUICK_SEC = 30
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_valid,
  input  logic [3:0]    key_digit,
  input  logic          key_start,
  input  logic          key_cancel,
  input  logic          door_open,
  output logic [1:0]    state,
  output logic [TW-1:0] time_left,
  output logic          show_c,
  output logic          show_k,
  output logic          show_t,
  output logic          spin_m,
  output logic          mag_on,
  output logic          done
);

  localparam int PW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ENTRY = 2'b01,
    COOK  = 2'b10,
    PAUSE = 2'b11
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] time_q, time_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          done_q, done_d;

  logic          digit_ok;
  logic          start_ok;
  logic          wrap;
  logic [TW+3:0] acc;
  logic [TW-1:0] acc_sat;

  assign digit_ok = key_valid && (key_digit <= 4'd9);
  assign start_ok = key_start && !door_open;
  assign wrap     = (presc_q == PW'(TICK_DIV - 1));

  // time*10 + d is computed with 4 spare bits so the overflow is visible before clamping
  assign acc     = ({4'b0, time_q} << 3) + ({4'b0, time_q} << 1) + {{TW{1'b0}}, key_digit};
  assign acc_sat = (acc > {4'b0, {TW{1'b1}}}) ? {TW{1'b1}} : acc[TW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      time_q  <= '0;
      presc_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      presc_q <= presc_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    presc_d = presc_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        presc_d = '0;
        if (key_cancel) begin
          time_d = '0;
        end else if (key_start) begin
          if (!door_open) begin
            state_d = COOK;
            time_d  = TW'(QUICK_SEC);
          end
        end else if (digit_ok) begin
          state_d = ENTRY;
          time_d  = TW'(key_digit);
        end
      end
      ENTRY: begin
        presc_d = '0;
        if (key_cancel) begin
          state_d = IDLE;
          time_d  = '0;
        end else if (key_start) begin
          if (start_ok) state_d = (time_q == '0) ? IDLE : COOK;
        end else if (digit_ok) begin
          time_d = acc_sat;
        end
      end
      COOK: begin
        // a pause edge freezes the partial second, even when it coincides with a wrap
        if (key_cancel || door_open) begin
          state_d = PAUSE;
        end else if (wrap) begin
          presc_d = '0;
          if (time_q <= TW'(1)) begin
            state_d = IDLE;
            time_d  = '0;
            done_d  = 1'b1;
          end else begin
            time_d = time_q - TW'(1);
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      PAUSE: begin
        if (key_cancel) begin
          state_d = IDLE;
          time_d  = '0;
          presc_d = '0;
        end else if (start_ok) begin
          state_d = COOK;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign state     = state_q;
  assign time_left = time_q;
  assign show_c    = (state_q == IDLE);
  assign show_k    = (state_q == ENTRY);
  assign show_t    = (state_q == COOK) || (state_q == PAUSE);
  assign spin_m    = (state_q == COOK);
  assign mag_on    = (state_q == COOK);
  assign done      = done_q;

endmodule

// File: tb/tb_controle_mic_fsm.sv
// Bench for controle_mic_fsm (TW=8, TICK_DIV=4, QUICK_SEC=30): vector table plus
// cook sequences, expectations queued at drive time and checked after each edge.
module tb_controle_mic_fsm;

  localparam logic [1:0] S_I = 2'd0, S_E = 2'd1, S_C = 2'd2, S_P = 2'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       key_start = 1'b0;
  logic       key_cancel = 1'b0;
  logic       door_open = 1'b0;
  logic [1:0] state;
  logic [7:0] time_left;
  logic       show_c, show_k, show_t, spin_m, mag_on, done;

  controle_mic_fsm #(.TW(8), .TICK_DIV(4), .QUICK_SEC(30)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_digit(key_digit),
    .key_start(key_start), .key_cancel(key_cancel), .door_open(door_open),
    .state(state), .time_left(time_left), .show_c(show_c), .show_k(show_k),
    .show_t(show_t), .spin_m(spin_m), .mag_on(mag_on), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [1:0] st;
    logic [7:0] tl;
    logic       dn;
  } exp_t;

  typedef struct {
    string      name;
    logic       rs, kv;
    logic [3:0] kd;
    logic       ks, kc, dr;
    logic [1:0] st;
    logic [7:0] tl;
    logic       dn;
  } vec_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always begin
    @(posedge clk);
    #1;
    if (sbq.size() > 0) begin
      exp_t e;
      logic [4:0] eo, ao;
      e  = sbq.pop_front();
      eo = {e.st == S_I, e.st == S_E, e.st[1], e.st == S_C, e.st == S_C};
      ao = {show_c, show_k, show_t, spin_m, mag_on};
      n_checks++;
      if (state === e.st && time_left === e.tl && done === e.dn && ao === eo)
        n_pass++;
      else
        $display("FAIL %s: got state=%0d time_left=%0d done=%b ckttm=%b, want state=%0d time_left=%0d done=%b ckttm=%b",
                 e.name, state, time_left, done, ao, e.st, e.tl, e.dn, eo);
    end
  end

  task automatic drive(input string n, input logic rs, kv, input logic [3:0] kd,
                       input logic ks, kc, dr, input logic [1:0] st,
                       input logic [7:0] tl, input logic dn);
    exp_t e;
    @(negedge clk);
    rst = rs; key_valid = kv; key_digit = kd;
    key_start = ks; key_cancel = kc; door_open = dr;
    e.name = n; e.st = st; e.tl = tl; e.dn = dn;
    sbq.push_back(e);
  endtask

  function automatic vec_t v(input string n, input logic rs, kv, input logic [3:0] kd,
                             input logic ks, kc, dr, input logic [1:0] st,
                             input logic [7:0] tl, input logic dn);
    vec_t r;
    r.name = n; r.rs = rs; r.kv = kv; r.kd = kd; r.ks = ks; r.kc = kc; r.dr = dr;
    r.st = st; r.tl = tl; r.dn = dn;
    return r;
  endfunction

  // Expected COOK trajectory: j edges after (re)entry with prescaler p0 and time t0
  task automatic cook_run(input string n, input int t0, input int p0, input int edges);
    for (int j = 1; j <= edges; j++) begin
      int t;
      t = t0 - (p0 + j) / 4;
      if (t <= 0) drive(n, 0, 0, 0, 0, 0, 0, S_I, 8'd0, 1'b1);
      else        drive(n, 0, 0, 0, 0, 0, 0, S_C, 8'(t), 1'b0);
    end
  endtask

  vec_t tbl[$];

  initial begin
    tbl.push_back(v("reset",        1,0,0,  0,0,0, S_I,   0, 0));
    tbl.push_back(v("digit1",       0,1,1,  0,0,0, S_E,   1, 0));
    tbl.push_back(v("digit2",       0,1,2,  0,0,0, S_E,  12, 0));
    tbl.push_back(v("code12_ign",   0,1,12, 0,0,0, S_E,  12, 0));
    tbl.push_back(v("cancel_entry", 0,0,0,  0,1,0, S_I,   0, 0));
    tbl.push_back(v("digit9a",      0,1,9,  0,0,0, S_E,   9, 0));
    tbl.push_back(v("digit9b",      0,1,9,  0,0,0, S_E,  99, 0));
    tbl.push_back(v("digit9_sat",   0,1,9,  0,0,0, S_E, 255, 0));
    tbl.push_back(v("code12_sat",   0,1,12, 0,0,0, S_E, 255, 0));
    tbl.push_back(v("digit_at_sat", 0,1,3,  0,0,0, S_E, 255, 0));
    tbl.push_back(v("cancel_sat",   0,0,0,  0,1,0, S_I,   0, 0));
    tbl.push_back(v("code15_idle",  0,1,15, 0,0,0, S_I,   0, 0));
    tbl.push_back(v("qstart_door",  0,0,0,  1,0,1, S_I,   0, 0));
    tbl.push_back(v("qstart",       0,0,0,  1,0,0, S_C,  30, 0));
    tbl.push_back(v("cook_digit",   0,1,5,  0,0,0, S_C,  30, 0));
    tbl.push_back(v("cancel_door",  0,0,0,  0,1,1, S_P,  30, 0));
    tbl.push_back(v("pause_digit",  0,1,4,  0,0,0, S_P,  30, 0));
    tbl.push_back(v("cancel_start", 0,0,0,  1,1,0, S_I,   0, 0));
    tbl.push_back(v("digit0",       0,1,0,  0,0,0, S_E,   0, 0));
    tbl.push_back(v("start_zero",   0,0,0,  1,0,0, S_I,   0, 0));
    tbl.push_back(v("digit5",       0,1,5,  0,0,0, S_E,   5, 0));
    tbl.push_back(v("start_open",   0,0,0,  1,0,1, S_E,   5, 0));
    tbl.push_back(v("start_vs_dig", 0,1,7,  1,0,0, S_C,   5, 0));
    tbl.push_back(v("cancel_cook",  0,0,0,  0,1,0, S_P,   5, 0));
    tbl.push_back(v("cancel_pause", 0,0,0,  0,1,0, S_I,   0, 0));

    // Reset then 10 quiet cycles
    drive("rst_idle", 1, 0, 0, 0, 0, 0, S_I, 8'd0, 1'b0);
    for (int i = 0; i < 10; i++) drive("idle10", 0, 0, 0, 0, 0, 0, S_I, 8'd0, 1'b0);

    foreach (tbl[i])
      drive(tbl[i].name, tbl[i].rs, tbl[i].kv, tbl[i].kd, tbl[i].ks, tbl[i].kc,
            tbl[i].dr, tbl[i].st, tbl[i].tl, tbl[i].dn);

    // 12 seconds: 48 COOK cycles, single done pulse
    drive("a_d1",    0, 1, 1, 0, 0, 0, S_E, 8'd1,  1'b0);
    drive("a_d2",    0, 1, 2, 0, 0, 0, S_E, 8'd12, 1'b0);
    drive("a_start", 0, 0, 0, 1, 0, 0, S_C, 8'd12, 1'b0);
    cook_run("a_cook", 12, 0, 48);
    drive("a_after", 0, 0, 0, 0, 0, 0, S_I, 8'd0, 1'b0);

    // 3 seconds with a door pause after the first decrement
    drive("b_d3",     0, 1, 3, 0, 0, 0, S_E, 8'd3, 1'b0);
    drive("b_start",  0, 0, 0, 1, 0, 0, S_C, 8'd3, 1'b0);
    cook_run("b_cook1", 3, 0, 4);
    drive("b_door",   0, 0, 0, 0, 0, 1, S_P, 8'd2, 1'b0);
    drive("b_st_open",0, 0, 0, 1, 0, 1, S_P, 8'd2, 1'b0);
    drive("b_resume", 0, 0, 0, 1, 0, 0, S_C, 8'd2, 1'b0);
    cook_run("b_cook2", 2, 0, 8);
    drive("b_after",  0, 0, 0, 0, 0, 0, S_I, 8'd0, 1'b0);

    // Door at the wrap edge: no decrement, partial second resumes
    drive("c_qstart", 0, 0, 0, 1, 0, 0, S_C, 8'd30, 1'b0);
    cook_run("c_cook", 30, 0, 3);
    drive("c_door_wrap", 0, 0, 0, 0, 0, 1, S_P, 8'd30, 1'b0);
    drive("c_resume",    0, 0, 0, 1, 0, 0, S_C, 8'd30, 1'b0);
    drive("c_wrap",      0, 0, 0, 0, 0, 0, S_C, 8'd29, 1'b0);
    drive("c_cancel1",   0, 0, 0, 0, 1, 0, S_P, 8'd29, 1'b0);
    drive("c_cancel2",   0, 0, 0, 0, 1, 0, S_I, 8'd0,  1'b0);

    // Reset during COOK: no done pulse
    drive("d_qstart", 0, 0, 0, 1, 0, 0, S_C, 8'd30, 1'b0);
    cook_run("d_cook", 30, 0, 5);
    drive("d_rst",    1, 0, 0, 0, 0, 0, S_I, 8'd0, 1'b0);
    drive("d_after",  0, 0, 0, 0, 0, 0, S_I, 8'd0, 1'b0);
    drive("d_after2", 0, 0, 0, 0, 0, 0, S_I, 8'd0, 1'b0);

    @(negedge clk);
    @(negedge clk);
    if (sbq.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sbq.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
